// File: rtl/bram_prog_mem.sv
// rtl/bram_prog_mem.sv - byte-writable program/data BRAM with pipelined read and streaming preload
module bram_prog_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int READ_LAT   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   w_addr,
    input  logic [DATA_WIDTH-1:0]   w_dat,
    input  logic [DATA_WIDTH/8-1:0] w_strb,
    input  logic                    w_enb,
    input  logic [ADDR_WIDTH-1:0]   r_addr,
    input  logic                    r_enb,
    output logic [DATA_WIDTH-1:0]   r_dat,
    output logic                    r_valid,
    input  logic                    ld_start,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic [DATA_WIDTH-1:0]   ld_dat,
    input  logic                    ld_last,
    output logic                    ld_busy,
    output logic                    ld_done,
    output logic [ADDR_WIDTH:0]     ld_cnt
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    state_t state;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  loading;
    logic                  ld_fire;
    logic                  rd_fire;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_dat;
    logic [NB-1:0]         wr_strb;

    assign loading = (state == LOAD);
    assign ld_fire = ld_valid & ld_ready;
    assign rd_fire = r_enb & ~loading;

    // The preload engine owns the write port for the whole LOAD phase.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = w_addr;
        wr_dat  = w_dat;
        wr_strb = w_strb;
        if (ld_fire) begin
            wr_en   = ~rst;
            wr_addr = ld_cnt[ADDR_WIDTH-1:0];
            wr_dat  = ld_dat;
            wr_strb = '1;
        end else if (!loading) begin
            wr_en = w_enb & ~rst;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < NB; k++) begin
                if (wr_strb[k]) begin
                    mem[wr_addr][8*k +: 8] <= wr_dat[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ld_ready <= 1'b0;
            ld_busy  <= 1'b0;
            ld_done  <= 1'b0;
            ld_cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (ld_start) begin
                        state    <= LOAD;
                        ld_ready <= 1'b1;
                        ld_busy  <= 1'b1;
                        ld_done  <= 1'b0;
                        ld_cnt   <= '0;
                    end
                end
                LOAD: begin
                    if (ld_fire) begin
                        ld_cnt <= ld_cnt + 1'b1;
                        // Last word or memory full: stop accepting.
                        if (ld_last || ld_cnt == (ADDR_WIDTH+1)'(DEPTH - 1)) begin
                            state    <= DONE;
                            ld_ready <= 1'b0;
                            ld_busy  <= 1'b0;
                            ld_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    ld_ready <= 1'b0;
                    ld_busy  <= 1'b0;
                end
            endcase
        end
    end

    logic [DATA_WIDTH-1:0] rd1_dat;
    logic                  rd1_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd1_dat   <= '0;
            rd1_valid <= 1'b0;
        end else begin
            rd1_valid <= rd_fire;
            if (rd_fire) begin
                rd1_dat <= mem[r_addr];
            end
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] rd2_dat;
            logic                  rd2_valid;
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd2_dat   <= '0;
                    rd2_valid <= 1'b0;
                end else begin
                    rd2_valid <= rd1_valid;
                    if (rd1_valid) begin
                        rd2_dat <= rd1_dat;
                    end
                end
            end
            assign r_dat   = rd2_dat;
            assign r_valid = rd2_valid;
        end else begin : g_lat1
            assign r_dat   = rd1_dat;
            assign r_valid = rd1_valid;
        end
    endgenerate
endmodule

// File: tb/tb_bram_prog_mem.sv
// tb/tb_bram_prog_mem.sv - directed bench driving a 1-cycle and a 2-cycle instance in lockstep
module tb_bram_prog_mem;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  w_addr = '0;
    logic [31:0] w_dat = '0;
    logic [3:0]  w_strb = '0;
    logic        w_enb = 1'b0;
    logic [2:0]  r_addr = '0;
    logic        r_enb = 1'b0;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_dat = '0;
    logic        ld_last = 1'b0;

    logic [31:0] r_dat_a, r_dat_b;
    logic        r_valid_a, r_valid_b;
    logic        ld_ready_a, ld_ready_b, ld_busy_a, ld_busy_b, ld_done_a, ld_done_b;
    logic [3:0]  ld_cnt_a, ld_cnt_b;

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    bram_prog_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .READ_LAT(1)) u_a (
        .clk(clk), .rst(rst), .w_addr(w_addr), .w_dat(w_dat), .w_strb(w_strb), .w_enb(w_enb),
        .r_addr(r_addr), .r_enb(r_enb), .r_dat(r_dat_a), .r_valid(r_valid_a),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready_a), .ld_dat(ld_dat),
        .ld_last(ld_last), .ld_busy(ld_busy_a), .ld_done(ld_done_a), .ld_cnt(ld_cnt_a)
    );

    bram_prog_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .READ_LAT(2)) u_b (
        .clk(clk), .rst(rst), .w_addr(w_addr), .w_dat(w_dat), .w_strb(w_strb), .w_enb(w_enb),
        .r_addr(r_addr), .r_enb(r_enb), .r_dat(r_dat_b), .r_valid(r_valid_b),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready_b), .ld_dat(ld_dat),
        .ld_last(ld_last), .ld_busy(ld_busy_b), .ld_done(ld_done_b), .ld_cnt(ld_cnt_b)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] addr, input logic [31:0] dat, input logic [3:0] strb);
        w_addr = addr; w_dat = dat; w_strb = strb; w_enb = 1'b1;
        tick();
        w_enb = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] addr, input logic [31:0] exp, input string tag);
        r_addr = addr; r_enb = 1'b1;
        tick();
        r_enb = 1'b0;
        ncmp++;
        if (r_valid_a !== 1'b1 || r_dat_a !== exp) begin
            nfail++; $display("FAIL %s lat1: valid=%b dat=%h, required valid=1 dat=%h", tag, r_valid_a, r_dat_a, exp);
        end
        ncmp++;
        if (r_valid_b !== 1'b0) begin
            nfail++; $display("FAIL %s lat2 early: valid=%b, required 0", tag, r_valid_b);
        end
        tick();
        ncmp++;
        if (r_valid_b !== 1'b1 || r_dat_b !== exp) begin
            nfail++; $display("FAIL %s lat2: valid=%b dat=%h, required valid=1 dat=%h", tag, r_valid_b, r_dat_b, exp);
        end
        ncmp++;
        if (r_valid_a !== 1'b0) begin
            nfail++; $display("FAIL %s lat1 pulse: valid=%b, required 0", tag, r_valid_a);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ncmp++;
        if ({r_valid_a, r_valid_b, ld_ready_a, ld_ready_b, ld_busy_a, ld_busy_b, ld_done_a, ld_done_b} !== 8'h00) begin
            nfail++; $display("FAIL reset_flags: got %b%b%b%b%b%b%b%b, required 00000000", r_valid_a, r_valid_b,
                              ld_ready_a, ld_ready_b, ld_busy_a, ld_busy_b, ld_done_a, ld_done_b);
        end
        ncmp++;
        if (ld_cnt_a !== 4'd0 || ld_cnt_b !== 4'd0 || r_dat_a !== 32'h0 || r_dat_b !== 32'h0) begin
            nfail++; $display("FAIL reset_vals: cnt=%0d/%0d dat=%h/%h, required 0", ld_cnt_a, ld_cnt_b, r_dat_a, r_dat_b);
        end
    endtask

    task automatic test_preload();
        logic [31:0] words [4];
        words[0] = 32'h00500093; words[1] = 32'h00a00113;
        words[2] = 32'h002081b3; words[3] = 32'h00000013;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ncmp++;
        if (ld_ready_a !== 1'b1 || ld_busy_b !== 1'b1) begin
            nfail++; $display("FAIL preload_enter: ready=%b busy=%b, required 1 1", ld_ready_a, ld_busy_b);
        end
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b0;
            tick();
            ld_dat = words[i]; ld_valid = 1'b1; ld_last = (i == 3);
            tick();
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        ncmp++;
        if (ld_done_a !== 1'b1 || ld_done_b !== 1'b1 || ld_cnt_a !== 4'd4 || ld_cnt_b !== 4'd4) begin
            nfail++; $display("FAIL preload_done: done=%b/%b cnt=%0d/%0d, required 1 cnt=4", ld_done_a, ld_done_b, ld_cnt_a, ld_cnt_b);
        end
        ncmp++;
        if (ld_ready_a !== 1'b0 || ld_busy_a !== 1'b0) begin
            nfail++; $display("FAIL preload_idle: ready=%b busy=%b, required 0 0", ld_ready_a, ld_busy_a);
        end
        for (int i = 0; i < 4; i++) do_read(3'(i), words[i], "preload_rd");
    endtask

    task automatic test_strobes();
        do_write(3'd5, 32'hDEADBEEF, 4'b1111);
        do_write(3'd5, 32'h00001200, 4'b0010);
        do_write(3'd5, 32'h55555555, 4'b0000);
        do_read(3'd5, 32'hDEAD12EF, "strobe_rd");
    endtask

    task automatic test_collision();
        do_write(3'd7, 32'h11111111, 4'b1111);
        w_addr = 3'd7; w_dat = 32'h22222222; w_strb = 4'b1111; w_enb = 1'b1;
        r_addr = 3'd7; r_enb = 1'b1;
        tick();
        w_enb = 1'b0; r_enb = 1'b0;
        ncmp++;
        if (r_valid_a !== 1'b1 || r_dat_a !== 32'h11111111) begin
            nfail++; $display("FAIL collide_lat1: valid=%b dat=%h, required 1 11111111", r_valid_a, r_dat_a);
        end
        tick();
        ncmp++;
        if (r_valid_b !== 1'b1 || r_dat_b !== 32'h11111111) begin
            nfail++; $display("FAIL collide_lat2: valid=%b dat=%h, required 1 11111111", r_valid_b, r_dat_b);
        end
        do_read(3'd7, 32'h22222222, "collide_next");
    endtask

    task automatic test_block_during_load();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        w_addr = 3'd0; w_dat = 32'hFFFFFFFF; w_strb = 4'b1111; w_enb = 1'b1;
        r_addr = 3'd0; r_enb = 1'b1;
        ld_dat = 32'hCAFE0000; ld_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            ld_valid = 1'b0;
            ncmp++;
            if (r_valid_a !== 1'b0 || r_valid_b !== 1'b0) begin
                nfail++; $display("FAIL block_rvalid: valid=%b/%b, required 0/0", r_valid_a, r_valid_b);
            end
        end
        ld_dat = 32'hCAFE0001; ld_valid = 1'b1; ld_last = 1'b1;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0; w_enb = 1'b0; r_enb = 1'b0;
        ncmp++;
        if (r_valid_a !== 1'b0 || ld_done_a !== 1'b1 || ld_cnt_a !== 4'd2) begin
            nfail++; $display("FAIL block_end: valid=%b done=%b cnt=%0d, required 0 1 2", r_valid_a, ld_done_a, ld_cnt_a);
        end
        tick();
        ncmp++;
        if (r_valid_b !== 1'b0) begin
            nfail++; $display("FAIL block_rvalid_lat2: valid=%b, required 0", r_valid_b);
        end
        do_read(3'd0, 32'hCAFE0000, "block_rd0");
        do_read(3'd1, 32'hCAFE0001, "block_rd1");
    endtask

    task automatic test_overflow();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ncmp++;
        if (ld_done_a !== 1'b0 || ld_cnt_a !== 4'd0 || ld_ready_b !== 1'b1) begin
            nfail++; $display("FAIL ovf_restart: done=%b cnt=%0d ready=%b, required 0 0 1", ld_done_a, ld_cnt_a, ld_ready_b);
        end
        ld_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ld_dat = 32'h1000 + 32'(i);
            tick();
            ncmp++;
            if (ld_ready_a !== (i < 7) || ld_ready_b !== (i < 7)) begin
                nfail++; $display("FAIL ovf_ready[%0d]: ready=%b/%b, required %b", i, ld_ready_a, ld_ready_b, (i < 7));
            end
            ncmp++;
            if (ld_cnt_a !== 4'((i < 8) ? i + 1 : 8)) begin
                nfail++; $display("FAIL ovf_cnt[%0d]: cnt=%0d, required %0d", i, ld_cnt_a, (i < 8) ? i + 1 : 8);
            end
        end
        ld_valid = 1'b0;
        ncmp++;
        if (ld_done_b !== 1'b1 || ld_cnt_b !== 4'd8) begin
            nfail++; $display("FAIL ovf_done: done=%b cnt=%0d, required 1 8", ld_done_b, ld_cnt_b);
        end
        do_read(3'd0, 32'h1000, "ovf_rd0");
        do_read(3'd1, 32'h1001, "ovf_rd1");
        do_read(3'd7, 32'h1007, "ovf_rd7");
    endtask

    task automatic test_reset_midload();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1;
        ld_dat = 32'hAAAA0000;
        tick();
        ld_dat = 32'hAAAA0001;
        tick();
        ld_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ncmp++;
        if (ld_busy_a !== 1'b0 || ld_cnt_a !== 4'd0 || ld_ready_a !== 1'b0 || r_valid_a !== 1'b0) begin
            nfail++; $display("FAIL midrst: busy=%b cnt=%0d ready=%b valid=%b, required 0 0 0 0", ld_busy_a, ld_cnt_a, ld_ready_a, r_valid_a);
        end
        do_read(3'd0, 32'hAAAA0000, "midrst_rd0");
        do_read(3'd1, 32'hAAAA0001, "midrst_rd1");
        do_read(3'd2, 32'h1002, "midrst_rd2");
        r_addr = 3'd0; r_enb = 1'b1;
        tick();
        r_enb = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        ncmp++;
        if (r_valid_b !== 1'b0) begin
            nfail++; $display("FAIL midrst_flush: valid=%b, required 0", r_valid_b);
        end
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ld_dat = 32'hBBBB0000; ld_valid = 1'b1; ld_last = 1'b1;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        ncmp++;
        if (ld_cnt_b !== 4'd1 || ld_done_b !== 1'b1) begin
            nfail++; $display("FAIL midrst_reload: cnt=%0d done=%b, required 1 1", ld_cnt_b, ld_done_b);
        end
        do_read(3'd0, 32'hBBBB0000, "reload_rd0");
        do_read(3'd1, 32'hAAAA0001, "reload_rd1");
    endtask

    initial begin
        test_reset();
        test_preload();
        test_strobes();
        test_collision();
        test_block_during_load();
        test_overflow();
        test_reset_midload();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/bram_prog_mem.md
Name: bram_prog_mem

Overview:
Parametrised successor to the 32-bit instruction BRAM: one write port, one read port, one clock. Adds per-byte write strobes, a selectable 1- or 2-cycle registered read, and a read-valid flag. Adds a streaming preload engine (valid/ready) that fills memory sequentially from address 0 before the core starts fetching. Used as instruction memory (preloaded) or data memory (byte writes) in rv32i_sc.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 10, word-address width; DEPTH = 2**ADDR_WIDTH words.
READ_LAT, 1, read latency in cycles; only 1 or 2 are legal.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
w_addr  in  ADDR_WIDTH  write word address
w_dat  in  DATA_WIDTH  write data
w_strb  in  DATA_WIDTH/8  byte write strobes; bit k writes byte k (bits 8k+7:8k)
w_enb  in  1  write enable
r_addr  in  ADDR_WIDTH  read word address
r_enb  in  1  read enable
r_dat  out  DATA_WIDTH  read data
r_valid  out  1  r_dat holds data for a read issued READ_LAT cycles earlier
ld_start  in  1  one-cycle pulse: begin preload at address 0
ld_valid  in  1  preload word valid
ld_ready  out  1  engine accepts a word this cycle
ld_dat  in  DATA_WIDTH  preload word
ld_last  in  1  marks the final preload word
ld_busy  out  1  preload in progress
ld_done  out  1  preload completed
ld_cnt  out  ADDR_WIDTH+1  number of words written by the current or last preload

Behaviour:
- Reset (rst=1 at a clk edge): r_dat=0, r_valid=0, ld_ready=0, ld_busy=0, ld_done=0, ld_cnt=0, FSM=IDLE, pipeline stages cleared. Memory contents are NOT cleared.
- FSM states: IDLE, LOAD, DONE.
  - IDLE --ld_start--> LOAD. Clears ld_cnt and ld_done.
  - LOAD: ld_ready=1, ld_busy=1. Each ld_valid&ld_ready cycle writes ld_dat (all bytes) at address ld_cnt[ADDR_WIDTH-1:0], then increments ld_cnt.
  - LOAD --(handshake with ld_last=1) or (handshake when ld_cnt==DEPTH-1)--> DONE. In the second case ld_cnt ends at DEPTH.
  - DONE: ld_done=1, ld_ready=0, ld_busy=0. DONE --ld_start--> LOAD (restart from address 0, ld_cnt=0).
- ld_start while in LOAD is ignored.
- ld_ready is registered: it is 1 from the cycle after ld_start is sampled through the cycle of the terminating handshake.
- While in LOAD, w_enb and r_enb are ignored: no user writes, and no r_valid pulses are generated.
- Write port (IDLE/DONE): on a clk edge with w_enb=1, mem[w_addr] byte k <= w_dat byte k for each w_strb[k]=1. Other bytes are unchanged. w_strb=0 makes the write a no-op.
- Read port (IDLE/DONE): r_enb sampled at edge N.
  - READ_LAT=1: r_dat=mem[r_addr] and r_valid=1 after edge N.
  - READ_LAT=2: a second register stage; data and r_valid=1 appear after edge N+1.
  - Fully pipelined: one read accepted per cycle.
  - When no read completes, r_valid=0 and r_dat holds its last value.
- Same-address read and write at the same edge: read-first. r_dat returns the pre-write contents; the new contents are visible on the next read.
- Reset mid-load: FSM returns to IDLE and ld_cnt=0. Words already written remain in memory. A read pipeline in flight is dropped (r_valid=0).
- Addresses are word addresses. No wrap or bounds check is needed, since the full ADDR_WIDTH range is valid.

Test Plan:
- Preload: ld_start, then stream 4 words 00500093, 00a00113, 002081b3, 00000013 with ld_last on word 4 and ld_valid gapped every other cycle -> ld_done=1, ld_cnt=4. Reads of addr 0..3 return those words with r_valid exactly READ_LAT cycles after each r_enb.
- Byte strobes: write DEADBEEF to addr 5 with strb=1111, then 00001200 with strb=0010 -> read addr 5 returns DEAD12EF.
- Read-first collision: mem[7]=11111111; write 22222222 to addr 7 and read addr 7 at the same edge -> r_dat=11111111; the next read returns 22222222.
- Load overflow (ADDR_WIDTH=3): stream 10 words with no ld_last -> ld_ready drops after the 8th handshake, ld_cnt=8, ld_done=1, and words 9–10 are not accepted.
- Reset mid-load: assert rst after 2 of 4 handshakes -> ld_busy=0, ld_cnt=0, r_valid=0. Addr 0..1 hold the loaded words; a fresh ld_start restarts at address 0.
- Blocking during load: assert w_enb to addr 0 and r_enb while in LOAD -> mem[0] holds the preload value and r_valid stays 0.
